// File: rtl/pkt_rr_output_arbiter.sv
// Packet-granular arbiter merging four show-ahead pkt FIFOs onto one 134-bit output bus.
// Latency: one grant cycle per packet, then popped words appear one cycle later on ov_pkt_data.
// Backpressure: i_out_almost_full stalls TX pops in place; DROP drains regardless of it.
module pkt_rr_output_arbiter #(
    parameter int MAX_PKT_WORDS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   iv_fifo_empty,
    output logic [3:0]   ov_fifo_rd,
    input  logic [133:0] iv_fifo_data0,
    input  logic [133:0] iv_fifo_data1,
    input  logic [133:0] iv_fifo_data2,
    input  logic [133:0] iv_fifo_data3,
    input  logic [3:0]   iv_prio_mask,
    input  logic         i_out_almost_full,
    output logic [133:0] ov_pkt_data,
    output logic         o_pkt_data_wr,
    output logic [1:0]   ov_cur_port,
    output logic         o_busy,
    output logic         o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam logic [1:0] F_HEAD   = 2'b01;
    localparam logic [1:0] F_TAIL   = 2'b10;
    localparam logic [7:0] LAST_CNT = 8'(MAX_PKT_WORDS - 1);

    state_e         state_q, state_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]     cur_port_q, cur_port_d;
    logic [7:0]     word_cnt_q, word_cnt_d;
    logic [133:0]   data_q, data_d;
    logic           wr_q, wr_d;
    logic           err_q, err_d;

    logic [133:0]   fifo_data [4];
    logic [133:0]   cur_word;
    logic [1:0]     cur_flag;
    logic [3:0]     req;
    logic [3:0]     cand;
    logic [1:0]     grant;
    logic           grant_found;
    logic [1:0]     grant_idx;
    logic           pop;

    assign fifo_data[0] = iv_fifo_data0;
    assign fifo_data[1] = iv_fifo_data1;
    assign fifo_data[2] = iv_fifo_data2;
    assign fifo_data[3] = iv_fifo_data3;

    assign cur_word = fifo_data[cur_port_q];
    assign cur_flag = cur_word[133:132];
    assign req      = ~iv_fifo_empty;

    // Pop strobe is combinational so the show-ahead word is consumed in the same cycle.
    always_comb begin
        ov_fifo_rd = 4'b0000;
        if (!rst && state_q != S_IDLE && !iv_fifo_empty[cur_port_q] &&
            (state_q == S_DROP || !i_out_almost_full)) begin
            ov_fifo_rd[cur_port_q] = 1'b1;
        end
    end

    assign pop = |ov_fifo_rd;

    // High-priority group wins outright; round-robin starts just after the last grant.
    always_comb begin
        cand        = ((req & iv_prio_mask) != 4'b0000) ? (req & iv_prio_mask) : req;
        grant       = 2'd0;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            grant_idx = rr_ptr_q + 2'(k);
            if (!grant_found && cand[grant_idx]) begin
                grant       = grant_idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_port_d = cur_port_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    rr_ptr_d   = grant;
                    cur_port_d = grant;
                    word_cnt_d = 8'd0;
                    if (fifo_data[grant][133:132] == F_HEAD) begin
                        state_d = S_TX;
                    end else begin
                        state_d = S_DROP;
                        err_d   = 1'b1;
                    end
                end
            end
            S_TX: begin
                if (pop) begin
                    wr_d       = 1'b1;
                    data_d     = cur_word;
                    word_cnt_d = word_cnt_q + 8'd1;
                    if (cur_flag == F_TAIL) begin
                        state_d = S_IDLE;
                    end else if (word_cnt_q == LAST_CNT) begin
                        // Over-long packet: close it with a forced tail and discard the rest.
                        data_d[133:132] = F_TAIL;
                        err_d           = 1'b1;
                        state_d         = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (pop && cur_flag == F_TAIL) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 2'd3;
            cur_port_q <= 2'd0;
            word_cnt_q <= 8'd0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_port_q <= cur_port_d;
            word_cnt_q <= word_cnt_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
        end
    end

    assign ov_pkt_data   = data_q;
    assign o_pkt_data_wr = wr_q;
    assign ov_cur_port   = cur_port_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_err         = err_q;

endmodule

// File: tb/tb_pkt_rr_output_arbiter.sv
// Bench for pkt_rr_output_arbiter: queue-based FIFO sources, packet-level reference model,
// directed scenarios with literal expectations followed by randomized traffic.
module tb_pkt_rr_output_arbiter;

    localparam int MAXW = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   iv_fifo_empty;
    logic [3:0]   ov_fifo_rd;
    logic [133:0] dat [4];
    logic [3:0]   iv_prio_mask;
    logic         i_out_almost_full;
    logic [133:0] ov_pkt_data;
    logic         o_pkt_data_wr;
    logic [1:0]   ov_cur_port;
    logic         o_busy;
    logic         o_err;

    pkt_rr_output_arbiter #(.MAX_PKT_WORDS(MAXW)) dut (
        .clk               (clk),
        .rst               (rst),
        .iv_fifo_empty     (iv_fifo_empty),
        .ov_fifo_rd        (ov_fifo_rd),
        .iv_fifo_data0     (dat[0]),
        .iv_fifo_data1     (dat[1]),
        .iv_fifo_data2     (dat[2]),
        .iv_fifo_data3     (dat[3]),
        .iv_prio_mask      (iv_prio_mask),
        .i_out_almost_full (i_out_almost_full),
        .ov_pkt_data       (ov_pkt_data),
        .o_pkt_data_wr     (o_pkt_data_wr),
        .ov_cur_port       (ov_cur_port),
        .o_busy            (o_busy),
        .o_err             (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rd_seen;
    always @(posedge clk) rd_seen <= ov_fifo_rd;

    logic [133:0] fq [4][$];

    int checks = 0;
    int errors = 0;

    // reference model: packet-level view of the arbiter
    bit           m_busy;
    bit           m_drop;
    int           m_port;
    int           m_rr;
    int           m_cnt;
    logic [133:0] m_data;
    bit           m_wr;
    bit           m_err;

    // phase statistics taken from the DUT
    int wr_cnt;
    int err_cnt;
    int pop_cnt;
    int grants [$];
    logic [1:0] last_wr_flag;
    bit prev_busy;
    int seq = 0;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    function automatic logic [133:0] mkw(input logic [1:0] f, input int port);
        seq++;
        return {f, 32'(port), 32'(seq), 32'($urandom), 36'($urandom)};
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            iv_fifo_empty[i] = (fq[i].size() == 0);
            dat[i] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic push_pkt(input int port, input int len, input bit bad, input bit rnd_body);
        logic [1:0] f;
        for (int w = 0; w < len; w++) begin
            if (w == 0)            f = bad ? (($urandom % 2 == 0) ? 2'b11 : 2'b00) : 2'b01;
            else if (w == len - 1) f = 2'b10;
            else                   f = (rnd_body && $urandom % 6 == 0) ? 2'b01 : 2'b11;
            fq[port].push_back(mkw(f, port));
        end
        drive();
    endtask

    task automatic clear_stats();
        wr_cnt = 0;
        err_cnt = 0;
        pop_cnt = 0;
        grants.delete();
    endtask

    // Evaluate what the last clock edge must have done, compare, then consume popped words.
    task automatic step();
        logic [3:0]   exp_rd;
        logic [3:0]   req;
        logic [3:0]   pool;
        logic [133:0] w;
        int           g;
        @(negedge clk);
        exp_rd = 4'b0000;
        m_wr   = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_port = 0;
            m_rr   = 3;
            m_cnt  = 0;
            m_data = '0;
        end else if (!m_busy) begin
            for (int i = 0; i < 4; i++) req[i] = (fq[i].size() != 0);
            pool = ((req & iv_prio_mask) != 0) ? (req & iv_prio_mask) : req;
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && pool[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            end
            if (g >= 0) begin
                m_rr   = g;
                m_port = g;
                m_cnt  = 0;
                m_busy = 1'b1;
                m_drop = (fq[g][0][133:132] != 2'b01);
                m_err  = m_drop;
            end
        end else if (fq[m_port].size() != 0 && (m_drop || !i_out_almost_full)) begin
            exp_rd[m_port] = 1'b1;
            w = fq[m_port][0];
            if (m_drop) begin
                if (w[133:132] == 2'b10) m_busy = 1'b0;
            end else begin
                m_wr  = 1'b1;
                m_cnt = m_cnt + 1;
                m_data = w;
                if (w[133:132] == 2'b10) begin
                    m_busy = 1'b0;
                end else if (m_cnt == MAXW) begin
                    m_data[133:132] = 2'b10;
                    m_err  = 1'b1;
                    m_drop = 1'b1;
                end
            end
        end
        chk("rd", 134'(rd_seen), 134'(exp_rd));
        chk("wr", 134'(o_pkt_data_wr), 134'(m_wr));
        chk("data", ov_pkt_data, m_data);
        chk("cur_port", 134'(ov_cur_port), 134'(m_port));
        chk("busy", 134'(o_busy), 134'(m_busy));
        chk("err", 134'(o_err), 134'(m_err));
        if (o_pkt_data_wr) begin
            wr_cnt++;
            last_wr_flag = ov_pkt_data[133:132];
        end
        if (o_err) err_cnt++;
        for (int i = 0; i < 4; i++) if (rd_seen[i]) pop_cnt++;
        if (o_busy && !prev_busy) grants.push_back(int'(ov_cur_port));
        prev_busy = o_busy;
        for (int i = 0; i < 4; i++) if (exp_rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        drive();
    endtask

    function automatic bit all_empty();
        return fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0;
    endfunction

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while (!(all_empty() && !m_busy && !o_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) timeout(name);
        step();
    endtask

    task automatic wait_wr(input string name, input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) timeout(name);
    endtask

    initial begin
        rst = 1'b1;
        i_out_almost_full = 1'b0;
        iv_prio_mask = 4'b0000;
        prev_busy = 1'b0;
        last_wr_flag = 2'b00;
        drive();
        repeat (3) step();
        chk("reset_busy", 134'(o_busy), 134'(0));
        chk("reset_wr", 134'(o_pkt_data_wr), 134'(0));
        chk("reset_data", ov_pkt_data, '0);
        chk("reset_port", 134'(ov_cur_port), 134'(0));
        rst = 1'b0;
        step();

        // four ports, one 3-word packet each, no priority
        clear_stats();
        for (int p = 0; p < 4; p++) push_pkt(p, 3, 1'b0, 1'b0);
        run_idle("t1_drain", 100);
        chk("t1_wr_count", 134'(wr_cnt), 134'(12));
        chk("t1_grant_count", 134'(grants.size()), 134'(4));
        for (int i = 0; i < grants.size() && i < 4; i++) chk("t1_grant_order", 134'(grants[i]), 134'(i));

        // priority group starves port 0 until port 2 is empty
        clear_stats();
        iv_prio_mask = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            push_pkt(0, 3, 1'b0, 1'b0);
            push_pkt(2, 3, 1'b0, 1'b0);
        end
        run_idle("t2_drain", 200);
        chk("t2_wr_count", 134'(wr_cnt), 134'(30));
        chk("t2_grant_count", 134'(grants.size()), 134'(10));
        for (int i = 0; i < grants.size() && i < 10; i++)
            chk("t2_grant_order", 134'(grants[i]), 134'((i < 5) ? 2 : 0));
        iv_prio_mask = 4'b0000;

        // almost_full stall mid-packet
        clear_stats();
        push_pkt(1, 4, 1'b0, 1'b0);
        wait_wr("t3_start", 2, 20);
        i_out_almost_full = 1'b1;
        begin
            int moved = 0;
            for (int c = 0; c < 6; c++) begin
                step();
                moved += int'(o_pkt_data_wr) + int'(rd_seen != 0);
            end
            chk("t3_stall_activity", 134'(moved), 134'(0));
        end
        i_out_almost_full = 1'b0;
        run_idle("t3_drain", 40);
        chk("t3_wr_count", 134'(wr_cnt), 134'(4));
        chk("t3_err_count", 134'(err_cnt), 134'(0));

        // malformed head is drained silently
        clear_stats();
        push_pkt(3, 3, 1'b1, 1'b0);
        run_idle("t4_drain", 40);
        chk("t4_err_count", 134'(err_cnt), 134'(1));
        chk("t4_wr_count", 134'(wr_cnt), 134'(0));
        chk("t4_pop_count", 134'(pop_cnt), 134'(3));

        // truncation of a 7-word packet at MAXW=4
        clear_stats();
        push_pkt(0, 7, 1'b0, 1'b0);
        run_idle("t5_drain", 40);
        chk("t5_wr_count", 134'(wr_cnt), 134'(4));
        chk("t5_err_count", 134'(err_cnt), 134'(1));
        chk("t5_pop_count", 134'(pop_cnt), 134'(7));
        chk("t5_last_flag", 134'(last_wr_flag), 134'(2'b10));

        // reset in the middle of a packet
        clear_stats();
        push_pkt(1, 3, 1'b0, 1'b0);
        wait_wr("t6_start", 1, 20);
        rst = 1'b1;
        step();
        chk("t6_rd", 134'(rd_seen), 134'(0));
        chk("t6_wr", 134'(o_pkt_data_wr), 134'(0));
        chk("t6_data", ov_pkt_data, '0);
        chk("t6_busy", 134'(o_busy), 134'(0));
        for (int p = 0; p < 4; p++) fq[p].delete();
        drive();
        step();
        rst = 1'b0;
        step();
        clear_stats();
        push_pkt(2, 3, 1'b0, 1'b0);
        push_pkt(0, 3, 1'b0, 1'b0);
        run_idle("t6_drain", 60);
        chk("t6_first_grant", 134'((grants.size() > 0) ? grants[0] : -1), 134'(0));

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 5 == 0) begin
                int p = $urandom % 4;
                if (fq[p].size() < 40) push_pkt(p, 2 + ($urandom % 6), ($urandom % 10 == 0), 1'b1);
            end
            i_out_almost_full = ($urandom % 10 < 3);
            if ($urandom % 25 == 0) iv_prio_mask = 4'($urandom);
            rst = ($urandom % 400 == 0);
            step();
        end
        rst = 1'b0;
        i_out_almost_full = 1'b0;
        run_idle("rand_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
